// File: rtl/register_dump_reader.sv
// Walks the register file two entries per read cycle (even index on RA, odd on RB)
// and streams every value out over a valid/ready port tagged with its index.
module register_dump_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  Start,
    input  logic                  Abort,
    output logic [ADDR_WIDTH-1:0] RA,
    output logic [ADDR_WIDTH-1:0] RB,
    input  logic [DATA_WIDTH-1:0] BusA,
    input  logic [DATA_WIDTH-1:0] BusB,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic [ADDR_WIDTH-1:0] OutIndex,
    output logic                  Busy,
    output logic                  Done
);

    localparam int K_W = ADDR_WIDTH - 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_REGS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND_A,
        SEND_B,
        DONE_S
    } state_t;

    state_t                  state;
    logic [K_W-1:0]          k;
    logic [DATA_WIDTH-1:0]   hold_a;
    logic [DATA_WIDTH-1:0]   hold_b;
    logic                    xfer;

    // Pair counter doubles as both read addresses: RA is the even half, RB the odd.
    assign RA       = {k, 1'b0};
    assign RB       = {k, 1'b1};
    assign xfer     = OutValid & OutReady;
    assign OutData  = (state == SEND_B) ? hold_b : hold_a;
    assign OutIndex = {k, state == SEND_B};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            k        <= '0;
            hold_a   <= '0;
            hold_b   <= '0;
            OutValid <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else if (Abort && state != IDLE) begin
            // Abort beats a same-cycle handshake: the presented entry is dropped.
            state    <= IDLE;
            k        <= '0;
            OutValid <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start && !Abort) begin
                        k     <= '0;
                        Busy  <= 1'b1;
                        state <= READ;
                    end
                end
                READ: begin
                    // Register file writes land on the falling edge, so both buses are settled here.
                    hold_a   <= BusA;
                    hold_b   <= BusB;
                    OutValid <= 1'b1;
                    state    <= SEND_A;
                end
                SEND_A: begin
                    if (xfer) begin
                        state <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (xfer) begin
                        OutValid <= 1'b0;
                        if (k == K_LAST) begin
                            Done  <= 1'b1;
                            state <= DONE_S;
                        end else begin
                            k     <= k + 1'b1;
                            state <= READ;
                        end
                    end
                end
                DONE_S: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    k     <= '0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    OutValid <= 1'b0;
                    Busy     <= 1'b0;
                    Done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_dump_reader.sv
// Bench for register_dump_reader: a behavioural 32 x 64 register file feeds the read
// ports; a per-cycle vector table plus hand sequences cover full dumps and corner cases.
module tb_register_dump_reader;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic        Abort;
    logic [4:0]  RA;
    logic [4:0]  RB;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic        OutValid;
    logic        OutReady;
    logic [63:0] OutData;
    logic [4:0]  OutIndex;
    logic        Busy;
    logic        Done;

    logic [63:0] rf [32];
    logic [63:0] exp_data [32];

    int n_cmp;
    int n_fail;

    register_dump_reader #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5),
        .NUM_REGS  (32)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Start   (Start),
        .Abort   (Abort),
        .RA      (RA),
        .RB      (RB),
        .BusA    (BusA),
        .BusB    (BusB),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .OutData (OutData),
        .OutIndex(OutIndex),
        .Busy    (Busy),
        .Done    (Done)
    );

    // X31 is hard-wired to zero in the register file.
    assign BusA = rf[RA];
    assign BusB = (RB == 5'd31) ? 64'd0 : rf[RB];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        start;
        logic        abort;
        logic        ready;
        logic        exp_valid;
        logic [4:0]  exp_index;
        logic [63:0] exp_data;
        logic        exp_busy;
        logic        exp_done;
        logic [4:0]  exp_ra;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic s, input logic a, input logic r, input logic v,
                                input logic [4:0] idx, input logic [63:0] d, input logic b,
                                input logic dn, input logic [4:0] ra);
        vec_t t;
        t.start = s; t.abort = a; t.ready = r; t.exp_valid = v; t.exp_index = idx;
        t.exp_data = d; t.exp_busy = b; t.exp_done = dn; t.exp_ra = ra;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) begin
            rf[i]       = (i == 31) ? 64'd0 : 64'(i);
            exp_data[i] = (i == 31) ? 64'd0 : 64'(i);
        end
    endtask

    // Caller has just pulsed Start and sits #1 after the sampling edge.
    // mode 0: ready high; 1: ready 1,0,0 repeating; 2: stall at index 1 and rewrite registers.
    task automatic run_dump(input int mode, input int restart_at, input int exp_done_cyc,
                            input string tag);
        int          n;
        int          cyc;
        int          dones;
        int          done_cyc;
        int          stall_cnt;
        logic        pstall;
        logic [4:0]  pidx;
        logic [63:0] pdat;
        logic        restarted;
        n = 0; cyc = 0; dones = 0; done_cyc = -1; stall_cnt = 0;
        pstall = 1'b0; pidx = '0; pdat = '0; restarted = 1'b0;
        Start = 1'b0;
        while (cyc < 400 && done_cyc < 0) begin
            case (mode)
                1: OutReady = (cyc % 3 == 0);
                2: begin
                    if (OutValid && OutIndex == 5'd1 && stall_cnt < 4) begin
                        OutReady = 1'b0;
                        if (stall_cnt == 0) begin
                            rf[4] = 64'hDEADBEEF;
                            rf[1] = 64'hBAD;
                            rf[0] = 64'hBAD0;
                        end
                        stall_cnt++;
                    end else begin
                        OutReady = 1'b1;
                    end
                end
                default: OutReady = 1'b1;
            endcase
            Start = (restart_at >= 0 && n == restart_at && !restarted);
            if (Start) restarted = 1'b1;
            if (pstall) begin
                chk({tag, "_stall_valid"}, 64'(OutValid), 64'd1);
                chk({tag, "_stall_index"}, 64'(OutIndex), 64'(pidx));
                chk({tag, "_stall_data"}, OutData, pdat);
            end
            if (OutValid && OutReady) begin
                if (n < 32) begin
                    chk({tag, "_index"}, 64'(OutIndex), 64'(n));
                    chk({tag, "_data"}, OutData, exp_data[n]);
                end
                n++;
            end
            pstall = OutValid && !OutReady;
            pidx   = OutIndex;
            pdat   = OutData;
            step();
            cyc++;
            if (Done) begin
                dones++;
                done_cyc = cyc;
            end
        end
        Start = 1'b0;
        OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (Done) dones++;
        end
        chk({tag, "_count"}, 64'(n), 64'd32);
        chk({tag, "_done_pulses"}, 64'(dones), 64'd1);
        if (exp_done_cyc >= 0) chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done_cyc));
        chk({tag, "_busy_after"}, 64'(Busy), 64'd0);
        chk({tag, "_valid_after"}, 64'(OutValid), 64'd0);
    endtask

    initial begin
        int  cnt;
        logic found;
        n_cmp = 0;
        n_fail = 0;
        Rst_n = 1'b0;
        Start = 1'b0;
        Abort = 1'b0;
        OutReady = 1'b0;
        preload();

        #2;
        chk("rst_valid", 64'(OutValid), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_ra", 64'(RA), 64'd0);
        chk("rst_rb", 64'(RB), 64'd1);
        chk("rst_data", OutData, 64'd0);
        chk("rst_index", 64'(OutIndex), 64'd0);
        #10 Rst_n = 1'b1;

        // Start/abort/backpressure walk through the first two pairs, one vector per clock.
        vecs[0]  = mk(0, 0, 0, 0, 5'd0, 64'd0, 0, 0, 5'd0);
        vecs[1]  = mk(1, 1, 0, 0, 5'd0, 64'd0, 0, 0, 5'd0);
        vecs[2]  = mk(1, 0, 0, 0, 5'd0, 64'd0, 1, 0, 5'd0);
        vecs[3]  = mk(0, 0, 0, 1, 5'd0, 64'd0, 1, 0, 5'd0);
        vecs[4]  = mk(0, 0, 0, 1, 5'd0, 64'd0, 1, 0, 5'd0);
        vecs[5]  = mk(0, 0, 1, 1, 5'd1, 64'd1, 1, 0, 5'd0);
        vecs[6]  = mk(0, 0, 1, 0, 5'd0, 64'd0, 1, 0, 5'd2);
        vecs[7]  = mk(0, 0, 0, 1, 5'd2, 64'd2, 1, 0, 5'd2);
        vecs[8]  = mk(0, 0, 1, 1, 5'd3, 64'd3, 1, 0, 5'd2);
        vecs[9]  = mk(1, 0, 0, 1, 5'd3, 64'd3, 1, 0, 5'd2);
        vecs[10] = mk(0, 1, 1, 0, 5'd0, 64'd0, 0, 0, 5'd0);
        for (int i = 0; i < 11; i++) begin
            Start = vecs[i].start;
            Abort = vecs[i].abort;
            OutReady = vecs[i].ready;
            step();
            chk($sformatf("vec%0d_valid", i), 64'(OutValid), 64'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_busy", i), 64'(Busy), 64'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_done", i), 64'(Done), 64'(vecs[i].exp_done));
            chk($sformatf("vec%0d_ra", i), 64'(RA), 64'(vecs[i].exp_ra));
            chk($sformatf("vec%0d_rb", i), 64'(RB), 64'(vecs[i].exp_ra) + 64'd1);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_index", i), 64'(OutIndex), 64'(vecs[i].exp_index));
                chk($sformatf("vec%0d_data", i), OutData, vecs[i].exp_data);
            end
        end
        Start = 1'b0;
        Abort = 1'b0;
        step();
        chk("abort_idle_busy", 64'(Busy), 64'd0);

        // Full dump, consumer always ready.
        Start = 1'b1;
        step();
        run_dump(0, -1, 48, "full");

        // Backpressure 1,0,0 repeating.
        Start = 1'b1;
        step();
        run_dump(1, -1, -1, "bp");

        // Start again while busy at entry 5 must not restart.
        Start = 1'b1;
        step();
        run_dump(0, 5, 48, "restart");

        // Abort in SEND_B of pair 7 with the consumer ready.
        Start = 1'b1;
        step();
        Start = 1'b0;
        OutReady = 1'b1;
        cnt = 0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (OutValid && OutIndex == 5'd15) begin
                found = 1'b1;
            end else begin
                if (OutValid && OutReady) cnt++;
                step();
            end
        end
        chk("abort_reached", 64'(found), 64'd1);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk("abort_valid", 64'(OutValid), 64'd0);
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        chk("abort_delivered", 64'(cnt), 64'd15);
        step();
        chk("abort_no_done", 64'(Done), 64'd0);
        Start = 1'b1;
        step();
        run_dump(0, -1, 48, "redump");

        // Registers rewritten while stalled at index 1 only affect pairs not yet read.
        exp_data[4] = 64'hDEADBEEF;
        Start = 1'b1;
        step();
        run_dump(2, -1, -1, "wr");
        preload();

        // Asynchronous reset in the middle of a SEND_A cycle.
        Start = 1'b1;
        step();
        Start = 1'b0;
        OutReady = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (OutValid) found = 1'b1;
            else step();
        end
        chk("areset_reached", 64'(found), 64'd1);
        #3 Rst_n = 1'b0;
        #1;
        chk("areset_valid", 64'(OutValid), 64'd0);
        chk("areset_busy", 64'(Busy), 64'd0);
        chk("areset_done", 64'(Done), 64'd0);
        chk("areset_ra", 64'(RA), 64'd0);
        chk("areset_rb", 64'(RB), 64'd1);
        @(negedge Clk);
        Rst_n = 1'b1;
        OutReady = 1'b1;
        step();
        step();
        chk("areset_no_resume", 64'(OutValid), 64'd0);
        chk("areset_idle_busy", 64'(Busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
